// File: rtl/avmm_pio_pkg.sv
// Shared definitions for the Avalon-MM PIO initiator.
// Contents:
//   - command op encodings (3-bit cmd_op)
//   - initiator FSM state enum
//   - register offsets of the PIO target
//   - op_legal() helper used at command accept
package avmm_pio_pkg;

  localparam logic [2:0] OP_WRITE = 3'd0;
  localparam logic [2:0] OP_READ  = 3'd1;
  localparam logic [2:0] OP_SET   = 3'd2;
  localparam logic [2:0] OP_CLR   = 3'd3;
  localparam logic [2:0] OP_POLL  = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    GAP     = 3'd4,
    RESP    = 3'd5
  } state_e;

  localparam logic [2:0] PIO_DATA    = 3'd0;
  localparam logic [2:0] PIO_DIR     = 3'd1;
  localparam logic [2:0] PIO_IRQMASK = 3'd2;
  localparam logic [2:0] PIO_EDGE    = 3'd3;
  localparam logic [2:0] PIO_OUTSET  = 3'd4;
  localparam logic [2:0] PIO_OUTCLR  = 3'd5;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_POLL;
  endfunction

endpackage

// File: rtl/avmm_pio_initiator.sv
// Avalon-MM initiator for a PIO-style target. Takes one command at a time
// and turns it into single-beat target transfers.
// Ports:
//   clk, reset           single clock, synchronous active-high reset
//   cmd_valid/cmd_ready  command handshake (ready only while idle)
//   cmd_op/addr/data/mask  WRITE, READ, SET, CLR, POLL command fields
//   rsp_valid/data/err   one-cycle response pulse, no backpressure
//   avm_*                Avalon-MM initiator side (read, active-low write)
module avmm_pio_initiator
  import avmm_pio_pkg::*;
#(
  parameter int ADDR_W       = 3,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int POLL_MAX     = 1000,
  parameter int POLL_GAP     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [DATA_W-1:0] cmd_mask,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_read,
  output logic              avm_write_n,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest
);

  localparam logic [2:0]  LAT_INIT   = 3'(READ_LATENCY);
  localparam logic [15:0] POLL_LIMIT = 16'(POLL_MAX);
  localparam logic [7:0]  GAP_LAST   = (POLL_GAP > 0) ? 8'(POLL_GAP - 1) : 8'd0;
  localparam bit          GAP_EN     = (POLL_GAP > 0);

  state_e            state, state_nx;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q, mask_q, wdata_q, rsp_data_q;
  logic              rsp_err_q;
  logic [2:0]        lat_cnt;
  logic [15:0]       poll_cnt;
  logic [7:0]        gap_cnt;

  logic rd_last, poll_hit, poll_last;

  // Last cycle of the read latency window: readdata is valid now.
  assign rd_last   = (lat_cnt == 3'd1);
  assign poll_hit  = ((avm_readdata ^ data_q) & mask_q) == '0;
  assign poll_last = (poll_cnt + 16'd1) == POLL_LIMIT;

  assign avm_address   = addr_q;
  assign avm_writedata = wdata_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_err       = rsp_err_q;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Strobes are gated by reset so an aborted transfer drops off the bus in
  // the same cycle reset is seen, not one edge later.
  always_comb begin
    state_nx       = state;
    cmd_ready      = 1'b0;
    rsp_valid      = 1'b0;
    avm_chipselect = 1'b0;
    avm_read       = 1'b0;
    avm_write_n    = 1'b1;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (!op_legal(cmd_op))     state_nx = RESP;
          else if (cmd_op == OP_WRITE) state_nx = WR_REQ;
          else                       state_nx = RD_REQ;
        end
      end
      RD_REQ: begin
        avm_chipselect = !reset;
        avm_read       = !reset;
        if (!avm_waitrequest) state_nx = RD_WAIT;
      end
      RD_WAIT: begin
        if (rd_last) begin
          case (op_q)
            OP_READ:        state_nx = RESP;
            OP_SET, OP_CLR: state_nx = WR_REQ;
            default: begin
              if (poll_hit || poll_last) state_nx = RESP;
              else if (GAP_EN)           state_nx = GAP;
              else                       state_nx = RD_REQ;
            end
          endcase
        end
      end
      WR_REQ: begin
        avm_chipselect = !reset;
        avm_write_n    = reset;
        if (!avm_waitrequest) state_nx = RESP;
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_nx = RD_REQ;
      end
      RESP: begin
        rsp_valid = !reset;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q       <= OP_WRITE;
      addr_q     <= '0;
      data_q     <= '0;
      mask_q     <= '0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      lat_cnt    <= '0;
      poll_cnt   <= '0;
      gap_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q     <= cmd_op;
            addr_q   <= cmd_addr;
            data_q   <= cmd_data;
            mask_q   <= cmd_mask;
            poll_cnt <= '0;
            if (!op_legal(cmd_op)) begin
              rsp_data_q <= '0;
              rsp_err_q  <= 1'b1;
            end else if (cmd_op == OP_WRITE) begin
              wdata_q <= cmd_data;
            end
          end
        end
        RD_REQ: begin
          if (!avm_waitrequest) lat_cnt <= LAT_INIT;
        end
        RD_WAIT: begin
          if (rd_last) begin
            rsp_data_q <= avm_readdata;
            rsp_err_q  <= 1'b0;
            case (op_q)
              OP_SET: wdata_q <= avm_readdata | data_q;
              OP_CLR: wdata_q <= avm_readdata & ~data_q;
              OP_POLL: begin
                if (!poll_hit) begin
                  if (poll_last) rsp_err_q <= 1'b1;
                  else           poll_cnt  <= poll_cnt + 16'd1;
                  gap_cnt <= '0;
                end
              end
              default: ;
            endcase
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        WR_REQ: begin
          if (!avm_waitrequest) begin
            rsp_data_q <= wdata_q;
            rsp_err_q  <= 1'b0;
          end
        end
        GAP: gap_cnt <= gap_cnt + 8'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_avmm_pio_initiator.sv
// Scoreboard bench: the driver pushes the expected response (data, err,
// arrival cycle) per command; a forked monitor pops and compares on every
// rsp_valid. A 4-bit PIO model with read latency 1 sits on the Avalon side.
module tb_avmm_pio_initiator;
  import avmm_pio_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [2:0]  cmd_addr = 3'd0;
  logic [31:0] cmd_data = 32'd0;
  logic [31:0] cmd_mask = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [2:0]  avm_address;
  logic        avm_chipselect, avm_read, avm_write_n;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata = 32'd0;
  logic        avm_waitrequest = 1'b0;

  avmm_pio_initiator #(
    .ADDR_W(3), .DATA_W(32), .READ_LATENCY(1), .POLL_MAX(5), .POLL_GAP(2)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_read(avm_read), .avm_write_n(avm_write_n),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;

  // Bus activity counters, written only by the monitor.
  int n_rcs = 0, n_rd = 0, n_wcs = 0, n_wr = 0;
  int rd_cyc[$];

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t sbq[$];

  // PIO model: DATA write drives out_port, DATA read returns in_val.
  logic [3:0] out_port = 4'd0;
  logic [3:0] in_port = 4'd0;
  logic       loopback = 1'b0;
  int         rise_after = 0;
  logic [3:0] in_val;
  assign in_val = (loopback ? out_port : in_port) |
                  ((rise_after != 0 && n_rd > rise_after) ? 4'h1 : 4'h0);

  always @(posedge clk) begin
    if (avm_chipselect && !avm_write_n && !avm_waitrequest) begin
      case (avm_address)
        PIO_DATA:   out_port <= avm_writedata[3:0];
        PIO_OUTSET: out_port <= out_port | avm_writedata[3:0];
        PIO_OUTCLR: out_port <= out_port & ~avm_writedata[3:0];
        default: ;
      endcase
    end
    if (avm_chipselect && avm_read && !avm_waitrequest)
      avm_readdata <= (avm_address == PIO_DATA) ? {28'd0, in_val} : 32'd0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (avm_chipselect && avm_read) begin
        n_rcs++;
        if (!avm_waitrequest) begin n_rd++; rd_cyc.push_back(cyc); end
      end
      if (avm_chipselect && !avm_write_n) begin
        n_wcs++;
        if (!avm_waitrequest) n_wr++;
      end
      if (avm_chipselect) chk("rd_wr_exclusive", 32'(avm_read & ~avm_write_n), 32'd0);
      if (rsp_valid) begin
        if (sbq.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
        else begin
          e = sbq.pop_front();
          chk("rsp_data", rsp_data, e.data);
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
          chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  endtask

  // Issue one command; lat = cycles from handshake cycle to rsp_valid.
  task automatic send(input logic [2:0] op, input logic [2:0] addr,
                      input logic [31:0] data, input logic [31:0] mask,
                      input logic [31:0] exp_data, input logic exp_err,
                      input int lat, input bit expect_rsp);
    int n = 0;
    @(negedge clk);
    cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_mask = mask;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    if (!cmd_ready) chk("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
    if (expect_rsp) sbq.push_back('{exp_data, exp_err, cyc + lat});
    @(posedge clk); #1;
    // Junk on the command bus while busy must be ignored.
    cmd_valid = 1'b0; cmd_op = 3'd7; cmd_addr = 3'd7;
    cmd_data = 32'hFFFF_FFFF; cmd_mask = 32'hFFFF_FFFF;
  endtask

  task automatic wait_rsp(output int ready_hi);
    int n = 0;
    ready_hi = 0;
    while (sbq.size() != 0 && n < 300) begin
      @(negedge clk); #1;
      if (cmd_ready && sbq.size() != 0) ready_hi++;
      n++;
    end
    if (sbq.size() != 0) begin
      chk("rsp_timeout", 32'(sbq.size()), 32'd0);
      sbq.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int rh, b_rcs, b_wcs, b_rd, b_q;
    fork monitor(); join_none

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_cs", 32'(avm_chipselect), 32'd0);
    chk("rst_read", 32'(avm_read), 32'd0);
    chk("rst_write_n", 32'(avm_write_n), 32'd1);
    chk("rst_address", 32'(avm_address), 32'd0);
    chk("rst_writedata", avm_writedata, 32'd0);

    // WRITE 0x5 to DATA: response in cycle 2, one write strobe cycle.
    b_rcs = n_rcs; b_wcs = n_wcs;
    send(OP_WRITE, PIO_DATA, 32'h5, 32'h0, 32'h5, 1'b0, 2, 1'b1);
    wait_rsp(rh);
    chk("wr_out_port", 32'(out_port), 32'h5);
    chk("wr_cs_cycles", 32'(n_wcs - b_wcs), 32'd1);
    chk("wr_no_read", 32'(n_rcs - b_rcs), 32'd0);

    // READ with in_port=0xA: response in cycle 3, one read strobe cycle.
    in_port = 4'hA; b_rcs = n_rcs;
    send(OP_READ, PIO_DATA, 32'h0, 32'h0, 32'h0000_000A, 1'b0, 3, 1'b1);
    wait_rsp(rh);
    chk("rd_strobe_cycles", 32'(n_rcs - b_rcs), 32'd1);

    // RMW with output looped back to input: 5|2=7, then 7&~4=3.
    loopback = 1'b1;
    send(OP_SET, PIO_DATA, 32'h2, 32'h0, 32'h7, 1'b0, 4, 1'b1);
    wait_rsp(rh);
    chk("set_out_port", 32'(out_port), 32'h7);
    send(OP_CLR, PIO_DATA, 32'h4, 32'h0, 32'h3, 1'b0, 4, 1'b1);
    wait_rsp(rh);
    chk("clr_out_port", 32'(out_port), 32'h3);
    loopback = 1'b0;

    // Illegal op: immediate error response with zero data, no bus traffic.
    b_rcs = n_rcs; b_wcs = n_wcs;
    send(3'd6, 3'd3, 32'hDEAD, 32'h0, 32'h0, 1'b1, 1, 1'b1);
    wait_rsp(rh);
    chk("illegal_no_bus", 32'((n_rcs - b_rcs) + (n_wcs - b_wcs)), 32'd0);

    // POLL bit0 rising after the 3rd read: 4 reads, read strobes 4 cycles
    // apart (RD_WAIT + 2 gap cycles between them), response in cycle 15.
    in_port = 4'h0; b_rd = n_rd; b_q = rd_cyc.size(); rise_after = n_rd + 3;
    send(OP_POLL, PIO_DATA, 32'h1, 32'h1, 32'h1, 1'b0, 15, 1'b1);
    wait_rsp(rh);
    rise_after = 0;
    chk("poll_reads", 32'(n_rd - b_rd), 32'd4);
    for (int i = 0; i < 3; i++)
      chk("poll_spacing", 32'(rd_cyc[b_q+i+1] - rd_cyc[b_q+i]), 32'd4);

    // POLL that never matches: timeout after exactly 5 reads, cycle 19.
    b_rd = n_rd;
    send(OP_POLL, PIO_DATA, 32'hF, 32'hF, 32'h0, 1'b1, 19, 1'b1);
    wait_rsp(rh);
    chk("poll_to_reads", 32'(n_rd - b_rd), 32'd5);
    chk("poll_to_ready_low", 32'(rh), 32'd0);

    // WRITE stalled by waitrequest for 3 cycles: response slips to cycle 5.
    avm_waitrequest = 1'b1;
    send(OP_WRITE, PIO_DIR, 32'h3C, 32'h0, 32'h3C, 1'b0, 5, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_ctl", {26'd0, avm_chipselect, avm_write_n, avm_read, avm_address},
          {26'd0, 1'b1, 1'b0, 1'b0, PIO_DIR});
      chk("stall_wdata", avm_writedata, 32'h3C);
    end
    @(posedge clk); #1 avm_waitrequest = 1'b0;
    wait_rsp(rh);

    // Reset during RD_WAIT of a READ: no response, idle right after.
    in_port = 4'h9;
    send(OP_READ, PIO_DATA, 32'h0, 32'h0, 32'h0, 1'b0, 0, 1'b0);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_rdwait_cs", 32'(avm_chipselect), 32'd0);
    chk("rst_rdwait_read", 32'(avm_read), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_rel_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rel_rsp", 32'(rsp_valid), 32'd0);
    repeat (3) @(negedge clk);

    // Reset in the middle of a stalled write drops the strobes at once.
    avm_waitrequest = 1'b1;
    send(OP_WRITE, PIO_DATA, 32'hF, 32'h0, 32'h0, 1'b0, 0, 1'b0);
    @(negedge clk);
    chk("stall_cs_before_rst", 32'(avm_chipselect), 32'd1);
    reset = 1'b1; #1;
    chk("rst_wr_cs", 32'(avm_chipselect), 32'd0);
    chk("rst_wr_write_n", 32'(avm_write_n), 32'd1);
    @(posedge clk); #1 reset = 1'b0; avm_waitrequest = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_wr_no_write", 32'(out_port), 32'h3);

    // Normal operation resumes after reset.
    in_port = 4'h6;
    send(OP_READ, PIO_DATA, 32'h0, 32'h0, 32'h6, 1'b0, 3, 1'b1);
    wait_rsp(rh);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
